// File: rtl/alu_z_stage.sv
// Z result register pair with one- or two-beat output sequencing.
// Optional zero/negative flag outputs are enabled by defining ALU_Z_FLAGS_EN.
module alu_z_stage #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_wide,
    input  logic [2*DATA_WIDTH-1:0]  result,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_is_hi,
    output logic [DATA_WIDTH-1:0]    z_high,
    output logic [DATA_WIDTH-1:0]    z_low,
    output logic [COUNT_WIDTH-1:0]   cap_count
`ifdef ALU_Z_FLAGS_EN
    ,
    output logic                     z_flag,
    output logic                     n_flag
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND_LO = 2'd1;
    localparam logic [1:0] SEND_HI = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_wide;
    logic [DATA_WIDTH-1:0]  r_z_high;
    logic [DATA_WIDTH-1:0]  r_z_low;
    logic [COUNT_WIDTH-1:0] r_cap_count;
    logic                   w_last_hs;
    logic                   w_cap;

    // Final beat handshake frees the stage in the same cycle, allowing back-to-back capture.
    assign w_last_hs = out_ready &
                       ((r_state == SEND_HI) | ((r_state == SEND_LO) & ~r_wide));
    assign in_ready  = ~flush & ((r_state == IDLE) | w_last_hs);
    assign w_cap     = in_valid & in_ready;

    assign out_valid = (r_state != IDLE);
    assign out_is_hi = (r_state == SEND_HI);
    assign out_data  = (r_state == SEND_HI) ? r_z_high : r_z_low;
    assign z_high    = r_z_high;
    assign z_low     = r_z_low;
    assign cap_count = r_cap_count;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else if (w_cap) begin
            w_state_nxt = SEND_LO;
        end else if (out_ready) begin
            case (r_state)
                SEND_LO: w_state_nxt = r_wide ? SEND_HI : IDLE;
                SEND_HI: w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= IDLE;
            r_wide      <= 1'b0;
            r_z_high    <= '0;
            r_z_low     <= '0;
            r_cap_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap) begin
                r_wide      <= in_wide;
                r_z_high    <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                r_z_low     <= result[DATA_WIDTH-1:0];
                r_cap_count <= r_cap_count + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef ALU_Z_FLAGS_EN
    logic r_z_flag;
    logic r_n_flag;

    assign z_flag = r_z_flag;
    assign n_flag = r_n_flag;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_z_flag <= 1'b0;
            r_n_flag <= 1'b0;
        end else if (w_cap) begin
            if (in_wide) begin
                r_z_flag <= (result == '0);
                r_n_flag <= result[2*DATA_WIDTH-1];
            end else begin
                r_z_flag <= (result[DATA_WIDTH-1:0] == '0);
                r_n_flag <= result[DATA_WIDTH-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_z_stage.sv
// Bench for alu_z_stage: directed scenarios plus randomized traffic against a beat-queue model.
module tb_alu_z_stage;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic        in_wide;
    logic [63:0] result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_is_hi;
    logic [31:0] z_high;
    logic [31:0] z_low;
    logic [7:0]  cap_count;
`ifdef ALU_Z_FLAGS_EN
    logic        z_flag;
    logic        n_flag;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_z_stage #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wide   (in_wide),
        .result    (result),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_is_hi (out_is_hi),
        .z_high    (z_high),
        .z_low     (z_low),
        .cap_count (cap_count)
`ifdef ALU_Z_FLAGS_EN
        ,
        .z_flag    (z_flag),
        .n_flag    (n_flag)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending output beats as a queue of {is_hi, data}; Z registers and counters.
    logic [32:0] mq[$];
    logic [31:0] m_zh = '0;
    logic [31:0] m_zl = '0;
    logic [7:0]  m_cnt = '0;
    logic        m_zf = 1'b0;
    logic        m_nf = 1'b0;

    function automatic logic model_ready();
        return !flush && (mq.size() == 0 || (out_ready && mq.size() == 1));
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            mq.delete();
            m_zh = '0; m_zl = '0; m_cnt = '0; m_zf = 1'b0; m_nf = 1'b0;
        end else begin
            logic rdy;
            rdy = model_ready();
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && rdy) begin
                    m_zh = result[63:32];
                    m_zl = result[31:0];
                    m_cnt = m_cnt + 8'd1;
                    mq.push_back({1'b0, result[31:0]});
                    if (in_wide) mq.push_back({1'b1, result[63:32]});
                    m_zf = in_wide ? (result == 64'd0) : (result[31:0] == 32'd0);
                    m_nf = in_wide ? result[63] : result[31];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clr === 1'b1) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
            check("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
            if (mq.size() > 0) begin
                check("out_data", {32'd0, out_data}, {32'd0, mq[0][31:0]});
                check("out_is_hi", {63'd0, out_is_hi}, {63'd0, mq[0][32]});
            end
            check("z_high", {32'd0, z_high}, {32'd0, m_zh});
            check("z_low", {32'd0, z_low}, {32'd0, m_zl});
            check("cap_count", {56'd0, cap_count}, {56'd0, m_cnt});
`ifdef ALU_Z_FLAGS_EN
            check("z_flag", {63'd0, z_flag}, {63'd0, m_zf});
            check("n_flag", {63'd0, n_flag}, {63'd0, m_nf});
`endif
        end
    end

    task automatic cyc(input logic iv, input logic w, input logic [63:0] res,
                       input logic fl, input logic ordy);
        in_valid = iv; in_wide = w; result = res; flush = fl; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] cnt0;
        clr = 1'b0;
        in_valid = 1'b0; in_wide = 1'b0; result = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_cap_count", {56'd0, cap_count}, 64'd0);
        @(posedge clk); #1;

        // Narrow op
        cyc(1'b1, 1'b0, 64'h0000_0000_1234_5678, 1'b0, 1'b1);
        check("narrow_valid", {63'd0, out_valid}, 64'd1);
        check("narrow_data", {32'd0, out_data}, 64'h1234_5678);
        check("narrow_is_hi", {63'd0, out_is_hi}, 64'd0);
        check("narrow_zhigh", {32'd0, z_high}, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        check("narrow_done", {63'd0, out_valid}, 64'd0);

        // Wide with backpressure, then back-to-back capture on the final beat
        cnt0 = cap_count;
        cyc(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
            check("bp_hold_data", {32'd0, out_data}, 64'h0000_0001);
            check("bp_hold_lo", {63'd0, out_is_hi}, 64'd0);
        end
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        check("wide_hi_data", {32'd0, out_data}, 64'hDEAD_BEEF);
        check("wide_hi_flag", {63'd0, out_is_hi}, 64'd1);
        in_valid = 1'b1; in_wide = 1'b0; result = 64'h5; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        check("b2b_valid", {63'd0, out_valid}, 64'd1);
        check("b2b_data", {32'd0, out_data}, 64'h5);
        check("b2b_count", {56'd0, cap_count}, {56'd0, cnt0 + 8'd2});

        // Flush in SEND_LO with a competing in_valid
        in_valid = 1'b1; in_wide = 1'b1; result = 64'hAAAA_AAAA_BBBB_BBBB; flush = 1'b1; out_ready = 1'b0;
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("flush_idle", {63'd0, out_valid}, 64'd0);
        check("flush_zlow", {32'd0, z_low}, 64'h5);
        check("flush_count", {56'd0, cap_count}, {56'd0, cnt0 + 8'd2});
        idle(1);

        // Async reset mid-SEND_HI
        cyc(1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        check("pre_rst_is_hi", {63'd0, out_is_hi}, 64'd1);
        out_ready = 1'b0;
        clr = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_zhigh", {32'd0, z_high}, 64'd0);
        check("mid_rst_zlow", {32'd0, z_low}, 64'd0);
        check("mid_rst_count", {56'd0, cap_count}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        idle(1);

        // 256 back-to-back narrow captures wrap the counter
        for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, {32'd0, 32'(i)}, 1'b0, 1'b1);
        idle(1);
        check("wrap_count", {56'd0, cap_count}, 64'd0);

`ifdef ALU_Z_FLAGS_EN
        cyc(1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        check("flag_wide_z", {63'd0, z_flag}, 64'd0);
        check("flag_wide_n", {63'd0, n_flag}, 64'd1);
        idle(2);
        cyc(1'b1, 1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1);
        check("flag_narrow_z", {63'd0, z_flag}, 64'd1);
        check("flag_narrow_n", {63'd0, n_flag}, 64'd0);
        idle(2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] r;
            r = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: r[31:0] = '0;
                1: r = '0;
                default: ;
            endcase
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, r,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
